// File: rtl/uart_fifo_core.sv
// UART core: shared 16x oversample tick, TX/RX FSMs, TX/RX FIFOs with valid/ready,
// internal loopback and framing/overrun pulses.

module uart_fifo_core_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_pop,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO refuses writes even when a pop lands in the same cycle.
    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign wr_en    = wr_valid && wr_ready;
    assign rd_en    = rd_pop && rd_valid;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module uart_fifo_core #(
    parameter int DIVISOR    = 54,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic                               tx,
    input  logic                               loopback_en,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    tx_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    output logic                               tx_busy,
    output logic                               frame_err,
    output logic                               overrun
);

    localparam int DW = $clog2(DIVISOR);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- tick generator ----------------
    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DW'(DIVISOR - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txf_head;
    logic                 txf_valid;
    logic                 tx_pop;

    uart_fifo_core_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (tx_valid),
        .wr_ready (tx_ready),
        .wr_data  (tx_data),
        .rd_data  (txf_head),
        .rd_valid (txf_valid),
        .rd_pop   (tx_pop),
        .count    (tx_count)
    );

    // ---------------- TX FSM ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [3:0]           tx_os, tx_os_n;
    logic [3:0]           tx_bit, tx_bit_n;
    logic                 tx_stop, tx_stop_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_line_n;
    logic                 tx_serial;
    logic                 loop_q;

    always_comb begin
        tx_state_n = tx_state;
        tx_os_n    = tx_os;
        tx_bit_n   = tx_bit;
        tx_stop_n  = tx_stop;
        tx_sh_n    = tx_sh;
        tx_pop     = 1'b0;
        if (tick) begin
            case (tx_state)
                TX_IDLE: begin
                    if (txf_valid) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = txf_head;
                        tx_os_n    = '0;
                        tx_state_n = TX_START;
                    end
                end
                TX_START: begin
                    if (tx_os == 4'd15) begin
                        tx_os_n    = '0;
                        tx_bit_n   = '0;
                        tx_state_n = TX_DATA;
                    end else begin
                        tx_os_n = tx_os + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_os == 4'd15) begin
                        tx_os_n = '0;
                        tx_sh_n = tx_sh >> 1;
                        if (tx_bit == 4'(DATA_BITS - 1)) begin
                            tx_stop_n  = '0;
                            tx_state_n = TX_STOP;
                        end else begin
                            tx_bit_n = tx_bit + 1'b1;
                        end
                    end else begin
                        tx_os_n = tx_os + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_os == 4'd15) begin
                        tx_os_n = '0;
                        if (tx_stop == 1'(STOP_BITS - 1)) begin
                            // Chain straight into the next start bit when more data is queued.
                            if (txf_valid) begin
                                tx_pop     = 1'b1;
                                tx_sh_n    = txf_head;
                                tx_state_n = TX_START;
                            end else begin
                                tx_state_n = TX_IDLE;
                            end
                        end else begin
                            tx_stop_n = tx_stop + 1'b1;
                        end
                    end else begin
                        tx_os_n = tx_os + 1'b1;
                    end
                end
                default: tx_state_n = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_sh_n[0];
            default:  tx_line_n = 1'b1;
        endcase
    end

    // Serial line and pin are registered from next-state so the pin is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_os     <= '0;
            tx_bit    <= '0;
            tx_stop   <= '0;
            tx_sh     <= '0;
            tx_serial <= 1'b1;
            tx        <= 1'b1;
            loop_q    <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_os     <= tx_os_n;
            tx_bit    <= tx_bit_n;
            tx_stop   <= tx_stop_n;
            tx_sh     <= tx_sh_n;
            tx_serial <= tx_line_n;
            tx        <= loopback_en ? 1'b1 : tx_line_n;
            loop_q    <= loopback_en;
        end
    end

    assign tx_busy = (tx_state != TX_IDLE);

    // ---------------- RX synchronizer ----------------
    logic rx_src;
    logic rx_s1, rx_s2, rx_prev;
    logic rx_fall;

    assign rx_src  = loop_q ? tx_serial : rx;
    assign rx_fall = rx_prev && !rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state, rx_state_n;
    logic [3:0]           rx_os, rx_os_n;
    logic [3:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_push;
    logic                 rxf_ready;
    logic                 ferr_n;
    logic                 ovr_n;

    always_comb begin
        rx_state_n = rx_state;
        rx_os_n    = rx_os;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_push    = 1'b0;
        ferr_n     = 1'b0;
        ovr_n      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_os_n    = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_os == 4'd7) begin
                        rx_os_n    = '0;
                        rx_bit_n   = '0;
                        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_os_n = rx_os + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_os == 4'd15) begin
                        rx_os_n = '0;
                        rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
                        if (rx_bit == 4'(DATA_BITS - 1)) begin
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 1'b1;
                        end
                    end else begin
                        rx_os_n = rx_os + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_os == 4'd15) begin
                        // Only the first stop bit is checked; back to IDLE to re-sync early.
                        rx_os_n    = '0;
                        rx_state_n = RX_IDLE;
                        if (!rx_s2) begin
                            ferr_n = 1'b1;
                        end else if (rxf_ready) begin
                            rx_push = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        rx_os_n = rx_os + 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_os     <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_os     <= rx_os_n;
            rx_bit    <= rx_bit_n;
            rx_sh     <= rx_sh_n;
            frame_err <= ferr_n;
            overrun   <= ovr_n;
        end
    end

    // ---------------- RX FIFO ----------------
    uart_fifo_core_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (rx_push),
        .wr_ready (rxf_ready),
        .wr_data  (rx_sh),
        .rd_data  (rx_data),
        .rd_valid (rx_valid),
        .rd_pop   (rx_ready),
        .count    (rx_count)
    );

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: DIVISOR=4, 8N1, FIFO_DEPTH=4.

module tb_uart_fifo_core;

    localparam int DIV = 4;
    localparam int DB  = 8;
    localparam int FD  = 4;
    localparam int BIT = 16 * DIV;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          tx;
    logic          loopback_en;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [2:0]    tx_count;
    logic [2:0]    rx_count;
    logic          tx_busy;
    logic          frame_err;
    logic          overrun;

    uart_fifo_core #(
        .DIVISOR    (DIV),
        .DATA_BITS  (DB),
        .STOP_BITS  (1),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .tx          (tx),
        .loopback_en (loopback_en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .tx_busy     (tx_busy),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int   ferr_cnt   = 0;
    int   ovr_cnt    = 0;
    int   lb_tx_bad  = 0;
    logic lb_prev    = 1'b0;

    always @(posedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun)   ovr_cnt  <= ovr_cnt + 1;
        lb_prev <= loopback_en;
    end

    always @(negedge clk) begin
        if (lb_prev && tx !== 1'b1) lb_tx_bad <= lb_tx_bad + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting, got none, expected event", name);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DB-1:0] d);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout_fail("push_wait");
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [DB-1:0] exp);
        check({name, "_valid"}, rx_valid, 1'b1);
        check(name, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        while (tx_busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) timeout_fail(name);
    endtask

    task automatic send_ext(input logic [DB-1:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on the negedge right after the accepting posedge.
    task automatic check_tx_frame(input string name, input logic [DB-1:0] d);
        logic [9:0] fr;
        logic       exp_bit;
        int n     = 1;
        int errs  = 0;
        int busy  = 0;
        fr = {1'b1, d, 1'b0};
        while (tx !== 1'b0 && n <= DIV + 3) begin
            @(negedge clk);
            n++;
        end
        check({name, "_start_latency_ok"}, (tx === 1'b0) && (n <= DIV + 1), 1'b1);
        for (int t = 0; t < 10 * BIT + 64; t++) begin
            exp_bit = (t < 10 * BIT) ? fr[t / BIT] : 1'b1;
            if (tx !== exp_bit) errs++;
            if (tx_busy === 1'b1) busy++;
            @(negedge clk);
        end
        check({name, "_wave_errs"}, errs, 0);
        check({name, "_busy_clks"}, busy, 10 * BIT);
    endtask

    typedef struct {
        logic          lb;
        logic [DB-1:0] data;
        logic          stop;
        logic          exp_word;
        logic [DB-1:0] exp_data;
        int            exp_ferr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int f0, o0, n;

        vecs[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[1] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[2] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1};
        vecs[4] = '{1'b0, 8'h12, 1'b1, 1'b1, 8'h12, 0};
        vecs[5] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[6] = '{1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 0};

        rst = 1'b1; rx = 1'b1; loopback_en = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_tx", tx, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        // Test 1: 0xA5 waveform on the pin
        wait_cycles(3);
        push(8'hA5);
        check_tx_frame("t1_a5", 8'hA5);

        // Table-driven single frames
        for (int v = 0; v < 7; v++) begin
            loopback_en = vecs[v].lb;
            wait_cycles(2);
            f0 = ferr_cnt;
            if (vecs[v].lb) begin
                push(vecs[v].data);
                wait_busy(1'b1, 50, $sformatf("vec%0d_busy_rise", v));
                wait_busy(1'b0, 2000, $sformatf("vec%0d_busy_fall", v));
            end else begin
                send_ext(vecs[v].data, vecs[v].stop);
            end
            wait_cycles(40);
            check($sformatf("vec%0d_rx_count", v), rx_count, vecs[v].exp_word ? 1 : 0);
            if (vecs[v].exp_word) pop_check($sformatf("vec%0d_rx_data", v), vecs[v].exp_data);
            check($sformatf("vec%0d_frame_err", v), ferr_cnt - f0, vecs[v].exp_ferr);
            loopback_en = 1'b0;
        end

        // Test 2: back-to-back loopback, pin stays high
        loopback_en = 1'b1;
        wait_cycles(2);
        f0 = ferr_cnt;
        lb_tx_bad = 0;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        n = 0;
        while (rx_count !== 3'd3 && n < 2400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2400) timeout_fail("t2_rx_count_wait");
        wait_busy(1'b0, 1000, "t2_busy_fall");
        wait_cycles(20);
        check("t2_rx_count", rx_count, 3);
        pop_check("t2_w0", 8'h00);
        pop_check("t2_w1", 8'hFF);
        pop_check("t2_w2", 8'h3C);
        check("t2_frame_err", ferr_cnt - f0, 0);
        check("t2_tx_pin_high", lb_tx_bad, 0);

        // Test 3: RX overrun with rx_ready held low
        do_reset();
        loopback_en = 1'b1;
        wait_cycles(2);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        push(8'h11);
        wait_busy(1'b1, 50, "t3_busy_rise");
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        check("t3_tx_count_full", tx_count, 4);
        check("t3_tx_ready_full", tx_ready, 1'b0);
        tx_data  = 8'h66;
        tx_valid = 1'b1;
        @(negedge clk);
        check("t3_blocked_write", tx_count, 4);
        push(8'h66);
        n = 0;
        while ((tx_busy !== 1'b0 || tx_count !== 3'd0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout_fail("t3_drain_wait");
        wait_cycles(40);
        check("t3_rx_count", rx_count, 4);
        check("t3_overruns", ovr_cnt - o0, 2);
        check("t3_frame_err", ferr_cnt - f0, 0);
        pop_check("t3_w0", 8'h11);
        pop_check("t3_w1", 8'h22);
        pop_check("t3_w2", 8'h33);
        pop_check("t3_w3", 8'h44);
        check("t3_rx_empty", rx_valid, 1'b0);
        loopback_en = 1'b0;
        wait_cycles(2);

        // Test 5: one-tick glitch rejected, then a real frame
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        wait_cycles(300);
        check("t5_glitch_rx_count", rx_count, 0);
        check("t5_glitch_ferr", ferr_cnt - f0, 0);
        check("t5_glitch_ovr", ovr_cnt - o0, 0);
        send_ext(8'h6A, 1'b1);
        wait_cycles(40);
        check("t5_after_rx_count", rx_count, 1);
        pop_check("t5_after_data", 8'h6A);

        // Test 6: reset in the middle of DATA
        push(8'hC3);
        wait_busy(1'b1, 50, "t6_busy_rise");
        push(8'h99);
        wait_cycles(3 * BIT);
        check("t6_pre_busy", tx_busy, 1'b1);
        check("t6_pre_tx_count", tx_count, 1);
        do_reset();
        check("t6_tx", tx, 1'b1);
        check("t6_tx_count", tx_count, 0);
        check("t6_rx_count", rx_count, 0);
        check("t6_tx_ready", tx_ready, 1'b1);
        check("t6_tx_busy", tx_busy, 1'b0);
        wait_cycles(2);
        push(8'h81);
        check_tx_frame("t6_81", 8'h81);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
